// File: rtl/parking_lot_controller.sv
// -----------------------------------------------------------------------------
// parking_lot_controller
//   Occupancy counter plus entry-gate sequencer for a single-lane car park.
//   The gate opens for a waiting car while the lot has room, closes after the
//   car enters or after TIMEOUT idle cycles, then rests for one cycle.
//   Requests made while the lot is full are answered with a one-cycle reject.
//
//   Optional build macro: PARKING_LOT_ERR_EN
//     defined   -> err goes sticky high on an overflow or underflow attempt
//     undefined -> err is tied to 0
//   Saturation of the count is identical in both builds.
// -----------------------------------------------------------------------------
module parking_lot_controller #(
   parameter int CAPACITY = 25,  // maximum cars, 1 .. 2**CNT_W-1
   parameter int CNT_W    = 5,   // occupancy counter width
   parameter int TIMEOUT  = 8    // open cycles without an enter pulse, >= 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enter,
   input  logic             exit,
   input  logic             entry_req,
   output logic             gate_open,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             reject,
   output logic             err
);

   // The timer only has to reach TIMEOUT-1, its value on the last open cycle.
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      CLOSE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_d;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_d;
   logic             reject_block;  // set after a reject until entry_req drops
   logic             reject_cond;
   logic             inc;
   logic             dec;

   assign full      = (count == CAP_V);
   assign empty     = (count == '0);
   assign gate_open = (state == OPEN);

   // Both pulses together mean one car in and one car out: no net change.
   assign inc = enter & ~exit;
   assign dec = exit & ~enter;

   assign reject_cond = (state == IDLE) && entry_req && full && !reject_block;

   // State and gate timer registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_d;
         timer <= timer_d;
      end
   end

   // Gate sequencing: next state and next timer value.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d = state;
      timer_d = '0;
      case (state)
         IDLE: begin
            if (entry_req && !full) begin
               state_d = OPEN;
            end
         end
         OPEN: begin
            if (enter || (timer == TMR_LAST)) begin
               state_d = CLOSE;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         CLOSE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Occupancy counter, saturating at both ends; counts in every gate state.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && !full) begin
         count <= count + 1'b1;
      end else if (dec && !empty) begin
         count <= count - 1'b1;
      end
   end

   // One-cycle reject pulse, re-armed only once entry_req is seen low.
   always_ff @(posedge clk) begin
      if (reset) begin
         reject       <= 1'b0;
         reject_block <= 1'b0;
      end else begin
         reject <= reject_cond;
         if (!entry_req) begin
            reject_block <= 1'b0;
         end else if (reject_cond) begin
            reject_block <= 1'b1;
         end
      end
   end

`ifdef PARKING_LOT_ERR_EN
   // Sticky error on an attempt to count past either end; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else if ((inc && full) || (dec && empty)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_parking_lot_controller.sv
// -----------------------------------------------------------------------------
// tb_parking_lot_controller
//   Directed stimulus with a behavioural model of the car park (cars present,
//   remaining open cycles of the gate, closing rest cycle, reject lockout).
//   Every falling edge the DUT outputs are compared with the model; literal
//   expectations at key points pin the model itself.
//   Honours PARKING_LOT_ERR_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_parking_lot_controller;

   localparam int CAPACITY = 25;
   localparam int CNT_W    = 5;
   localparam int TIMEOUT  = 8;
`ifdef PARKING_LOT_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             enter;
   logic             exit;
   logic             entry_req;
   logic             gate_open;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             reject;
   logic             err;

   int tests = 0;
   int fails = 0;

   parking_lot_controller #(
      .CAPACITY (CAPACITY),
      .CNT_W    (CNT_W),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enter     (enter),
      .exit      (exit),
      .entry_req (entry_req),
      .gate_open (gate_open),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .reject    (reject),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_enter(input int n);
      for (int i = 0; i < n; i++) begin
         enter = 1'b1;
         tick();
         enter = 1'b0;
         tick();
      end
   endtask

   // ---------------------------------------------------------------- model
   int m_count;       // cars in the lot
   int m_open_left;   // open cycles still to come (0 = gate shut)
   bit m_resting;     // current cycle is the one-cycle rest after closing
   bit m_blocked;     // a reject was issued and entry_req has not dropped yet
   bit m_reject;
   bit m_err;
   bit model_valid = 1'b0;

   always @(posedge clk) begin : model
      int c;
      int ol;
      bit rs;
      bit rj;
      bit bk;
      bit er;
      c  = m_count;
      ol = m_open_left;
      rs = 1'b0;
      rj = 1'b0;
      bk = m_blocked;
      er = m_err;
      if (reset) begin
         c  = 0;
         ol = 0;
         bk = 1'b0;
         er = 1'b0;
      end else begin
         if (m_open_left > 0) begin
            if (enter || m_open_left == 1) begin
               ol = 0;
               rs = 1'b1;
            end else begin
               ol = m_open_left - 1;
            end
         end else if (!m_resting && entry_req) begin
            if (m_count < CAPACITY) begin
               ol = TIMEOUT;
            end else if (!m_blocked) begin
               rj = 1'b1;
               bk = 1'b1;
            end
         end
         if (!entry_req) bk = 1'b0;
         if (enter && !exit) begin
            if (m_count == CAPACITY) er = er | ERR_EN;
            else                     c  = m_count + 1;
         end else if (exit && !enter) begin
            if (m_count == 0) er = er | ERR_EN;
            else              c  = m_count - 1;
         end
      end
      m_count     <= c;
      m_open_left <= ol;
      m_resting   <= rs;
      m_reject    <= rj;
      m_blocked   <= bk;
      m_err       <= er;
      if (reset) model_valid <= 1'b1;
   end

   // Compare every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (model_valid) begin
         check("cyc_gate_open", gate_open, (m_open_left > 0));
         check("cyc_count",     count,     m_count);
         check("cyc_full",      full,      (m_count == CAPACITY));
         check("cyc_empty",     empty,     (m_count == 0));
         check("cyc_reject",    reject,    m_reject);
         check("cyc_err",       err,       m_err);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      logic g [1:11];
      int   ones;

      reset = 1'b1; enter = 1'b0; exit = 1'b0; entry_req = 1'b0;
      tick();
      check("rst_gate_open", gate_open, 0);
      check("rst_count",     count,     0);
      check("rst_empty",     empty,     1);
      check("rst_full",      full,      0);
      check("rst_reject",    reject,    0);
      check("rst_err",       err,       0);
      reset = 1'b0;

      // Single request, car enters three cycles later.
      entry_req = 1'b1; tick(); entry_req = 1'b0;
      check("open_after_req", gate_open, 1);
      tick(); tick();
      enter = 1'b1; tick(); enter = 1'b0;
      check("closed_after_enter", gate_open, 0);
      check("count_after_enter",  count,     1);
      check("empty_after_enter",  empty,     0);
      tick();

      // Held request, no car: 8 open cycles, rest, then reopen.
      entry_req = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         g[i] = gate_open;
      end
      ones = 0;
      for (int i = 1; i <= 8; i++) if (g[i] === 1'b1) ones++;
      check("timeout_open_cycles", ones,  8);
      check("timeout_closed_1",    g[9],  0);
      check("timeout_closed_2",    g[10], 0);
      check("timeout_reopen",      g[11], 1);
      entry_req = 1'b0;
      repeat (10) tick();
      check("idle_after_timeout", gate_open, 0);

      // Underflow at zero.
      exit = 1'b1; tick(); exit = 1'b0;
      check("exit_to_zero", count, 0);
      exit = 1'b1; tick(); exit = 1'b0;
      check("underflow_count", count, 0);
      check("underflow_empty", empty, 1);
      check("underflow_err",   err,   ERR_EN);
      reset = 1'b1; tick(); reset = 1'b0;
      check("err_cleared", err, 0);

      // Simultaneous enter and exit at count 5.
      pulse_enter(5);
      check("count_five", count, 5);
      enter = 1'b1; exit = 1'b1; tick(); enter = 1'b0; exit = 1'b0;
      check("both_pulses_count", count, 5);

      // Fill the lot, then request while full.
      pulse_enter(20);
      check("filled_count", count, 25);
      check("filled_full",  full,  1);
      check("filled_err",   err,   0);
      entry_req = 1'b1; tick();
      check("reject_pulse",   reject,    1);
      check("full_gate_shut", gate_open, 0);
      tick();
      check("reject_single",  reject,    0);
      check("full_gate_shut2", gate_open, 0);
      tick();
      check("reject_held", reject, 0);
      entry_req = 1'b0; tick();
      entry_req = 1'b1; tick();
      check("reject_rearm", reject, 1);
      entry_req = 1'b0; tick();
      enter = 1'b1; tick(); enter = 1'b0;
      check("overflow_count", count, 25);
      check("overflow_full",  full,  1);
      check("overflow_err",   err,   ERR_EN);

      // Reset while open with seven cars, with an enter pulse on the same edge.
      reset = 1'b1; tick(); reset = 1'b0;
      pulse_enter(7);
      entry_req = 1'b1; tick(); entry_req = 1'b0;
      check("open_at_seven",  gate_open, 1);
      check("count_at_seven", count,     7);
      tick();
      reset = 1'b1; enter = 1'b1; tick(); reset = 1'b0; enter = 1'b0;
      check("midopen_rst_gate",   gate_open, 0);
      check("midopen_rst_count",  count,     0);
      check("midopen_rst_empty",  empty,     1);
      check("midopen_rst_reject", reject,    0);
      entry_req = 1'b1; tick(); entry_req = 1'b0;
      check("idle_after_reset", gate_open, 1);
      repeat (12) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/parking_lot_controller.md
PARKING_LOT_CONTROLLER -- requirements
Module: parking_lot_controller

Interface
REQ-001 SHALL have parameter CAPACITY, default 25, meaning the maximum number of cars in the lot (1..2**CNT_W-1).
REQ-002 SHALL have parameter CNT_W, default 5, meaning the occupancy counter width.
REQ-003 SHALL have parameter TIMEOUT, default 8, meaning the number of cycles the gate stays open with no enter pulse (>=1).
REQ-004 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enter  input  1  single-cycle pulse: one car completed entry (from the car detection block).
REQ-007 SHALL have port exit  input  1  single-cycle pulse: one car completed exit.
REQ-008 SHALL have port entry_req  input  1  level: a car is waiting at the entry gate.
REQ-009 SHALL have port gate_open  output  1  entry gate open command.
REQ-010 SHALL have port count  output  CNT_W  current occupancy.
REQ-011 SHALL have port full  output  1  high iff count == CAPACITY.
REQ-012 SHALL have port empty  output  1  high iff count == 0.
REQ-013 SHALL have port reject  output  1  single-cycle pulse: request denied because the lot is full.
REQ-014 SHALL have port err  output  1  sticky overflow/underflow flag (see Configuration).

Function
REQ-015 SHALL implement the FSM states IDLE, OPEN and CLOSE, with gate_open high only in OPEN.
REQ-016 SHALL go from IDLE to OPEN on a cycle where entry_req=1 and full=0; gate_open is high from the next cycle.
REQ-017 SHALL go from OPEN to CLOSE on the cycle an enter pulse is sampled.
REQ-018 SHALL go from OPEN to CLOSE when TIMEOUT cycles elapse in OPEN with no enter pulse; the timer starts at 0 on OPEN entry.
REQ-019 SHALL go from CLOSE to IDLE after exactly one cycle, regardless of entry_req, so a new request is accepted no earlier than two cycles after closing.
REQ-020 SHALL assert reject for one cycle when in IDLE, entry_req=1 and full=1, and SHALL NOT assert it again until entry_req has been sampled low.
REQ-021 SHALL raise count by 1 on the next cycle when enter=1 and exit=0, and lower it by 1 when exit=1 and enter=0.
REQ-022 SHALL leave count unchanged when enter and exit are both 1.
REQ-023 SHALL saturate count at CAPACITY on increment and at 0 on decrement.
REQ-024 SHALL count enter pulses in any FSM state; a tailgating car still updates occupancy.
REQ-025 SHALL derive full and empty combinationally from the count register, with no extra latency.
REQ-026 SHALL, when the count reaches CAPACITY while in OPEN, leave the gate to close by the normal enter/timeout rules.

Reset
REQ-027 SHALL, while reset=1 at a rising clk edge, set the state to IDLE, count=0, timer=0, gate_open=0, reject=0 and err=0; empty=1 and full=0 follow from count.
REQ-028 SHALL have reset override all other inputs, including mid-OPEN and on a simultaneous enter pulse (the pulse is dropped).

Configuration
REQ-029 SHALL, with macro PARKING_LOT_ERR_EN defined, set err sticky high on an enter-only pulse at count==CAPACITY or an exit-only pulse at count==0, cleared only by reset.
REQ-030 SHALL, with PARKING_LOT_ERR_EN undefined, keep the err port and tie it constantly to 0; saturation behaviour is identical in both builds.

Verification
REQ-031 SHALL cover: reset, then entry_req=1 for 1 cycle -> gate_open high next cycle; enter pulse 3 cycles later -> gate_open low next cycle, count=1, empty=0.
REQ-032 SHALL cover: entry_req=1 held with no enter -> gate_open high for exactly 8 cycles, then 1 cycle of CLOSE, then reopens.
REQ-033 SHALL cover: 25 enter pulses -> count=25, full=1; then entry_req=1 -> one reject pulse and gate_open stays 0; a 26th enter -> count stays 25 and err=1 only when PARKING_LOT_ERR_EN is defined.
REQ-034 SHALL cover: count=0 with an exit pulse -> count stays 0 and empty=1; then simultaneous enter and exit at count=5 -> count stays 5.
REQ-035 SHALL cover: reset asserted while in OPEN with count=7 -> the next cycle shows gate_open=0, count=0, state IDLE.
